// File: rtl/pipe_pkg.sv
// Shared definitions for the issue/hazard controller: instruction field layout,
// FSM state encoding and scoreboard entry format.
package pipe_pkg;

    localparam int INSTR_W     = 32;
    localparam int REG_W       = 5;
    localparam int CNT_W       = 16;

    localparam int DATASRC_BIT = 29;
    localparam int ALUOP_HI    = 28;
    localparam int ALUOP_LO    = 26;
    localparam int DEST_HI     = 25;
    localparam int DEST_LO     = 21;
    localparam int SRC1_HI     = 20;
    localparam int SRC1_LO     = 16;
    localparam int SRC2_HI     = 15;
    localparam int SRC2_LO     = 11;

    localparam logic [INSTR_W-1:0] NOP_INSTR     = 32'd0;
    localparam logic [CNT_W-1:0]   STALL_CNT_MAX = 16'hFFFF;

    localparam logic [1:0] ENC_RUN   = 2'd0;
    localparam logic [1:0] ENC_STALL = 2'd1;
    localparam logic [1:0] ENC_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        RUN   = ENC_RUN,
        STALL = ENC_STALL,
        DRAIN = ENC_DRAIN
    } state_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

    function automatic logic [REG_W-1:0] field_dest(input logic [INSTR_W-1:0] instr);
        return instr[DEST_HI:DEST_LO];
    endfunction

    function automatic logic [REG_W-1:0] field_src1(input logic [INSTR_W-1:0] instr);
        return instr[SRC1_HI:SRC1_LO];
    endfunction

    function automatic logic [REG_W-1:0] field_src2(input logic [INSTR_W-1:0] instr);
        return instr[SRC2_HI:SRC2_LO];
    endfunction

    function automatic logic field_datasrc(input logic [INSTR_W-1:0] instr);
        return instr[DATASRC_BIT];
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with two
// read-port match lookups and an any-valid summary.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter bit R0_IS_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_v,
    input  logic [REG_W-1:0] load_dest,
    input  logic [REG_W-1:0] rd_a,
    input  logic [REG_W-1:0] rd_b,
    output logic             match_a,
    output logic             match_b,
    output logic             any_valid
);

    sb_entry_t [DEPTH-1:0] entries;

    // Every cycle the pipe advances; the oldest entry retires off the end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '0;
        end else begin
            entries[0].v    <= load_v;
            entries[0].dest <= load_dest;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

    always_comb begin
        match_a   = 1'b0;
        match_b   = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].v) begin
                any_valid = 1'b1;
                if (entries[i].dest == rd_a) begin
                    match_a = 1'b1;
                end
                if (entries[i].dest == rd_b) begin
                    match_b = 1'b1;
                end
            end
        end
        // A hardwired zero register can never be the target of a pending write.
        if (R0_IS_ZERO && rd_a == '0) begin
            match_a = 1'b0;
        end
        if (R0_IS_ZERO && rd_b == '0) begin
            match_b = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue controller in front of the stage-1 pipeline register: valid/ready intake,
// RAW hazard stalls via bubbles, and a drain mode that empties the pipe.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter bit R0_IS_ZERO = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_we,
    output logic               instr_ready,
    input  logic               drain_req,
    output logic [INSTR_W-1:0] issue_instr,
    output logic               issue_we,
    output logic               issue_valid,
    output logic               stall,
    output logic               drained,
    output logic [CNT_W-1:0]   stall_cnt
);

    state_t           state;
    state_t           next_state;
    logic             hazard;
    logic             accept;
    logic             cnt_inc;
    logic             match1;
    logic             match2;
    logic             any_valid;
    logic             load_v;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             datasrc;

    assign dest    = field_dest(instr_in);
    assign src1    = field_src1(instr_in);
    assign src2    = field_src2(instr_in);
    assign datasrc = field_datasrc(instr_in);

    pipe_scoreboard #(
        .DEPTH      (DEPTH),
        .R0_IS_ZERO (R0_IS_ZERO)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .load_v    (load_v),
        .load_dest (dest),
        .rd_a      (src1),
        .rd_b      (src2),
        .match_a   (match1),
        .match_b   (match2),
        .any_valid (any_valid)
    );

    // Immediate-form instructions do not read src2, so only src1 can hazard for them.
    assign hazard      = instr_valid && (match1 || (!datasrc && match2));
    assign instr_ready = (state == RUN || state == STALL) && !hazard && !drain_req;
    assign accept      = instr_valid && instr_ready;
    assign load_v      = accept && instr_we && !(R0_IS_ZERO && dest == '0);

    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        unique case (state)
            RUN: begin
                if (drain_req) begin
                    next_state = DRAIN;
                end else if (hazard) begin
                    next_state = STALL;
                    cnt_inc    = 1'b1;
                end
            end
            STALL: begin
                if (drain_req) begin
                    next_state = DRAIN;
                end else if (hazard) begin
                    cnt_inc = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end
            DRAIN: begin
                if (!drain_req) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Anything not accepted this cycle goes out as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_instr <= NOP_INSTR;
            issue_we    <= 1'b0;
            issue_valid <= 1'b0;
        end else if (accept) begin
            issue_instr <= instr_in;
            issue_we    <= instr_we;
            issue_valid <= 1'b1;
        end else begin
            issue_instr <= NOP_INSTR;
            issue_we    <= 1'b0;
            issue_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (cnt_inc && stall_cnt != STALL_CNT_MAX) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall   = (state == STALL);
    assign drained = (state == DRAIN) && !any_valid;

endmodule
